// File: rtl/matmul_operand_loader_if.sv
// Byte-stream input and operand-pair output of the matmul operand loader.
// The loader takes the slave side; the producer/consumer pair takes master.
interface matmul_operand_loader_if #(
   parameter int CNT_W = 8
);
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      op_a;
   logic [15:0]      op_b;
   logic             op_valid;
   logic             op_ready;
   logic             reject;
   logic             reject_is_b;
   logic [CNT_W-1:0] rej_count;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output op_a,
      output op_b,
      output op_valid,
      input  op_ready,
      output reject,
      output reject_is_b,
      output rej_count
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  op_a,
      input  op_b,
      input  op_valid,
      output op_ready,
      input  reject,
      input  reject_is_b,
      input  rej_count
   );
endinterface

// File: rtl/matmul_operand_loader.sv
// Assembles 2x2 operand pairs (A then B) from a byte stream, rejects
// matrices with an all-zero row, and hands validated pairs to the core.
module matmul_operand_loader #(
   parameter bit CHECK_EN = 1'b1,
   parameter int CNT_W    = 8
) (
   input logic                   clk,
   input logic                   rst,
   matmul_operand_loader_if.slave bus
);

   typedef enum logic [2:0] {
      LOAD_A0,
      LOAD_A1,
      CHECK_A,
      LOAD_B0,
      LOAD_B1,
      CHECK_B,
      PUSH
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [15:0]      r_sh_a;
   logic [15:0]      r_sh_b;
   logic [15:0]      r_op_a;
   logic [15:0]      r_op_b;
   logic             r_op_valid;
   logic             r_reject;
   logic             r_reject_is_b;
   logic [CNT_W-1:0] r_rej_count;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_ld_a0;
   logic             w_ld_a1;
   logic             w_ld_b0;
   logic             w_ld_b1;
   logic             w_push;
   logic             w_fail;
   logic             w_fail_b;

   // Each packed byte is one matrix row, so a row is nonzero iff its byte is.
   function automatic logic rows_ok(input logic [15:0] m);
      return !CHECK_EN || ((m[15:8] != 8'h00) && (m[7:0] != 8'h00));
   endfunction

   assign w_accept = bus.in_valid && w_in_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_ld_a0     = 1'b0;
      w_ld_a1     = 1'b0;
      w_ld_b0     = 1'b0;
      w_ld_b1     = 1'b0;
      w_push      = 1'b0;
      w_fail      = 1'b0;
      w_fail_b    = 1'b0;
      unique case (r_state)
         LOAD_A0: begin
            w_in_ready = !rst;
            if (bus.in_valid && !rst) begin
               w_ld_a0     = 1'b1;
               w_state_nxt = LOAD_A1;
            end
         end
         LOAD_A1: begin
            w_in_ready = !rst;
            if (bus.in_valid && !rst) begin
               w_ld_a1     = 1'b1;
               w_state_nxt = CHECK_A;
            end
         end
         CHECK_A: begin
            if (rows_ok(r_sh_a)) begin
               w_state_nxt = LOAD_B0;
            end else begin
               w_fail      = 1'b1;
               w_state_nxt = LOAD_A0;
            end
         end
         LOAD_B0: begin
            w_in_ready = !rst;
            if (bus.in_valid && !rst) begin
               w_ld_b0     = 1'b1;
               w_state_nxt = LOAD_B1;
            end
         end
         LOAD_B1: begin
            w_in_ready = !rst;
            if (bus.in_valid && !rst) begin
               w_ld_b1     = 1'b1;
               w_state_nxt = CHECK_B;
            end
         end
         CHECK_B: begin
            if (rows_ok(r_sh_b)) begin
               w_state_nxt = PUSH;
            end else begin
               // Shadow A stays valid; only B is reloaded.
               w_fail      = 1'b1;
               w_fail_b    = 1'b1;
               w_state_nxt = LOAD_B0;
            end
         end
         PUSH: begin
            if (!r_op_valid || bus.op_ready) begin
               w_push      = 1'b1;
               w_state_nxt = LOAD_A0;
            end
         end
         default: begin
            w_state_nxt = LOAD_A0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= LOAD_A0;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_a <= '0;
         r_sh_b <= '0;
      end else begin
         if (w_ld_a0) begin
            r_sh_a[15:8] <= bus.in_data;
         end
         if (w_ld_a1) begin
            r_sh_a[7:0] <= bus.in_data;
         end
         if (w_ld_b0) begin
            r_sh_b[15:8] <= bus.in_data;
         end
         if (w_ld_b1) begin
            r_sh_b[7:0] <= bus.in_data;
         end
      end
   end

   // A push on the same cycle as a transfer refills without a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_op_valid <= 1'b0;
      end else if (w_push) begin
         r_op_a     <= r_sh_a;
         r_op_b     <= r_sh_b;
         r_op_valid <= 1'b1;
      end else if (bus.op_ready) begin
         r_op_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reject      <= 1'b0;
         r_reject_is_b <= 1'b0;
         r_rej_count   <= '0;
      end else begin
         r_reject <= w_fail;
         if (w_fail) begin
            r_reject_is_b <= w_fail_b;
            if (r_rej_count != CNT_MAX) begin
               r_rej_count <= r_rej_count + CNT_ONE;
            end
         end
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.op_a        = r_op_a;
   assign bus.op_b        = r_op_b;
   assign bus.op_valid    = r_op_valid;
   assign bus.reject      = r_reject;
   assign bus.reject_is_b = r_reject_is_b;
   assign bus.rej_count   = r_rej_count;

   logic w_unused;
   assign w_unused = w_accept;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Scoreboard bench for matmul_operand_loader: directed scenarios plus
// randomized streams checked against a byte-level reference model.
module tb_matmul_operand_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   matmul_operand_loader_if #(.CNT_W(8)) m ();
   matmul_operand_loader_if #(.CNT_W(8)) n ();
   matmul_operand_loader_if #(.CNT_W(2)) s ();

   matmul_operand_loader #(.CHECK_EN(1'b1), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .bus(m.slave)
   );
   matmul_operand_loader #(.CHECK_EN(1'b0), .CNT_W(8)) dut_nc (
      .clk(clk), .rst(rst), .bus(n.slave)
   );
   matmul_operand_loader #(.CHECK_EN(1'b1), .CNT_W(2)) dut_c2 (
      .clk(clk), .rst(rst), .bus(s.slave)
   );

   int vec = 0;
   int errs = 0;
   bit rnd_rdy = 1'b0;

   // Reference model state: bytes of the matrix being collected,
   // the accepted A matrix (if any) and the saturating reject count.
   logic [7:0]  mb[$];
   logic [15:0] ma;
   bit          have_a = 1'b0;
   int          mcnt = 0;
   logic [31:0] exp_pair[$];
   logic [8:0]  exp_rej[$];
   logic [7:0]  sq[$];

   task automatic fail(input string nm);
      vec++;
      errs++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic bit row_nz(input logic [3:0] e0, input logic [3:0] e1);
      return (e0 != 4'd0) || (e1 != 4'd0);
   endfunction

   task automatic model_accept(input logic [7:0] b);
      logic [15:0] mat;
      bit ok;
      mb.push_back(b);
      if (mb.size() == 2) begin
         mat = {mb[0], mb[1]};
         mb.delete();
         ok = row_nz(mat[15:12], mat[11:8]) && row_nz(mat[7:4], mat[3:0]);
         if (!ok) begin
            if (mcnt < 255) mcnt++;
            exp_rej.push_back({have_a, 8'(mcnt)});
         end else if (!have_a) begin
            ma = mat;
            have_a = 1'b1;
         end else begin
            exp_pair.push_back({ma, mat});
            have_a = 1'b0;
         end
      end
   endtask

   task automatic send(input logic [7:0] bs[$], input int gap_pct);
      int i = 0;
      int t = 0;
      while (i < bs.size()) begin
         @(negedge clk);
         if (int'($urandom_range(99)) < gap_pct) begin
            m.in_valid = 1'b0;
            m.in_data  = 8'($urandom);
            t++;
         end else begin
            m.in_valid = 1'b1;
            m.in_data  = bs[i];
            #1;
            if (m.in_ready) begin
               model_accept(bs[i]);
               i++;
               t = 0;
            end else begin
               t++;
            end
         end
         if (t > 500) begin
            fail("send_timeout");
            break;
         end
      end
      @(negedge clk);
      m.in_valid = 1'b0;
   endtask

   task automatic sendx(input int w, input logic [7:0] bs[$]);
      int  i = 0;
      int  t = 0;
      bit  rdy;
      while (i < bs.size() && t < 100) begin
         @(negedge clk);
         if (w == 0) begin
            n.in_valid = 1'b1;
            n.in_data  = bs[i];
         end else begin
            s.in_valid = 1'b1;
            s.in_data  = bs[i];
         end
         #1;
         rdy = (w == 0) ? n.in_ready : s.in_ready;
         if (rdy) i++;
         t++;
      end
      @(negedge clk);
      n.in_valid = 1'b0;
      s.in_valid = 1'b0;
      if (i < bs.size()) fail("sendx_timeout");
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drain(input int cyc);
      repeat (cyc) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      mb.delete();
      have_a = 1'b0;
      mcnt = 0;
      exp_pair.delete();
      exp_rej.delete();
      #1;
      chk("rst_op_valid", 32'(m.op_valid), 32'd0);
      chk("rst_rej_count", 32'(m.rej_count), 32'd0);
      chk("rst_in_ready", 32'(m.in_ready), 32'd0);
      drain(2);
      rst = 1'b0;
   endtask

   function automatic logic [7:0] rbyte();
      logic [3:0] hi;
      logic [3:0] lo;
      hi = ($urandom_range(99) < 35) ? 4'd0 : 4'($urandom_range(15, 1));
      lo = ($urandom_range(99) < 35) ? 4'd0 : 4'($urandom_range(15, 1));
      return {hi, lo};
   endfunction

   // Output monitor: pops the scoreboard on every transfer and reject pulse.
   initial begin : monitor
      bit          pv;
      logic [31:0] pd;
      pv = 1'b0;
      pd = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            pv = 1'b0;
         end else begin
            if (pv) begin
               vec++;
               if (m.op_valid !== 1'b1 || {m.op_a, m.op_b} !== pd) begin
                  errs++;
                  $display("FAIL hold: got v=%b %h expected v=1 %h at %0t",
                           m.op_valid, {m.op_a, m.op_b}, pd, $time);
               end
            end
            if (m.op_valid === 1'b1 && m.op_ready === 1'b1) begin
               if (exp_pair.size() == 0) fail("unexpected_pair");
               else chk("pair", {m.op_a, m.op_b}, exp_pair.pop_front());
            end
            if (m.reject === 1'b1) begin
               if (exp_rej.size() == 0) fail("unexpected_reject");
               else chk("reject", 32'({m.reject_is_b, m.rej_count}),
                        32'(exp_rej.pop_front()));
            end
            pv = m.op_valid && !m.op_ready;
            pd = {m.op_a, m.op_b};
         end
      end
   end

   initial begin : rnd_ready
      forever begin
         @(negedge clk);
         if (rnd_rdy) m.op_ready = ($urandom_range(99) < 60);
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit seen_rej;
      bit got;
      m.in_valid = 1'b0; m.in_data = '0; m.op_ready = 1'b1;
      n.in_valid = 1'b0; n.in_data = '0; n.op_ready = 1'b1;
      s.in_valid = 1'b0; s.in_data = '0; s.op_ready = 1'b1;
      rst = 1'b1;
      drain(3);
      #1;
      chk("reset_vals", {m.op_a, m.op_b}, 32'h0);
      chk("reset_ctl", 32'({m.op_valid, m.reject, m.reject_is_b,
                            m.rej_count, m.in_ready}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 32'(m.in_ready), 32'd1);

      // Basic pair with latency check.
      sq = '{8'h12, 8'h34, 8'h56, 8'h78};
      send(sq, 0);
      step();
      chk("t2_valid", 32'({m.op_valid, m.in_ready}), 32'd0);
      step();
      chk("t3_valid", 32'(m.op_valid), 32'd1);
      chk("t3_data", {m.op_a, m.op_b}, 32'h1234_5678);
      step();
      chk("t4_valid", 32'({m.op_valid, m.in_ready}), 32'd1);

      // A reject then a clean pair.
      sq = '{8'h00, 8'h34};
      send(sq, 0);
      step();
      chk("rejA", 32'({m.reject, m.reject_is_b, m.in_ready}), 32'b101);
      chk("rejA_cnt", 32'(m.rej_count), 32'd1);
      step();
      chk("rejA_pulse", 32'(m.reject), 32'd0);
      sq = '{8'h11, 8'h11, 8'h21, 8'h43};
      send(sq, 0);
      drain(5);

      // B reject keeps A.
      sq = '{8'h12, 8'h34, 8'h21, 8'h00, 8'h21, 8'h05};
      send(sq, 0);
      drain(5);
      chk("rej_is_b_hold", 32'({m.reject_is_b, m.rej_count}), 32'h102);

      // Back-pressure: pair 1 held, pair 2 parked in PUSH.
      m.op_ready = 1'b0;
      sq = '{8'h13, 8'h57, 8'h24, 8'h68, 8'h88, 8'h99, 8'hAA, 8'hBB};
      send(sq, 0);
      drain(3);
      #1;
      chk("park_data", {m.op_a, m.op_b}, 32'h1357_2468);
      chk("park_ctl", 32'({m.op_valid, m.in_ready}), 32'b10);
      @(negedge clk);
      m.op_ready = 1'b1;
      @(negedge clk);
      m.op_ready = 1'b0;
      #1;
      chk("b2b_valid", 32'(m.op_valid), 32'd1);
      chk("b2b_data", {m.op_a, m.op_b}, 32'h8899_AABB);
      drain(2);
      m.op_ready = 1'b1;
      drain(2);

      // Reset mid-operation with a pair parked in the output register.
      m.op_ready = 1'b0;
      sq = '{8'h31, 8'h42, 8'h53, 8'h64, 8'h77};
      send(sq, 0);
      drain(2);
      #1;
      chk("pre_rst_valid", 32'(m.op_valid), 32'd1);
      do_reset();
      m.op_ready = 1'b1;
      sq = '{8'h9A, 8'hBC, 8'hDE, 8'hF1};
      send(sq, 0);
      drain(5);
      chk("post_rst_empty", 32'(exp_pair.size()), 32'd0);

      // Randomized streams with gaps and random back-pressure.
      rnd_rdy = 1'b1;
      for (int c = 0; c < 6; c++) begin
         sq.delete();
         for (int k = 0; k < 40; k++) sq.push_back(rbyte());
         send(sq, 25);
      end
      rnd_rdy = 1'b0;
      @(negedge clk);
      m.op_ready = 1'b1;
      drain(20);
      chk("final_pairs_left", 32'(exp_pair.size()), 32'd0);
      chk("final_rej_left", 32'(exp_rej.size()), 32'd0);
      chk("final_rej_count", 32'(m.rej_count), 32'(mcnt));

      // Check disabled: an all-zero pair passes.
      sq = '{8'h00, 8'h00, 8'h00, 8'h00};
      sendx(0, sq);
      seen_rej = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         step();
         if (n.reject) seen_rej = 1'b1;
         if (n.op_valid) got = 1'b1;
      end
      chk("nc_valid", 32'(got), 32'd1);
      chk("nc_data", {n.op_a, n.op_b}, 32'h0);
      chk("nc_no_rej", 32'({seen_rej, n.rej_count}), 32'd0);

      // Narrow counter saturates.
      sq = '{8'h00, 8'h00, 8'h00, 8'h00};
      sendx(1, sq);
      drain(3);
      chk("c2_cnt2", 32'(s.rej_count), 32'd2);
      sq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      sendx(1, sq);
      drain(3);
      chk("c2_sat", 32'(s.rej_count), 32'd3);
      chk("c2_no_op", 32'(s.op_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
